// File: rtl/keystream_sequencer.sv
// -----------------------------------------------------------------------------
// keystream_sequencer
//
// Control sequencer for the ChaCha20 keystream PISO shifter. It accepts
// finished 512-bit blocks from the block core (valid/ready), strobes the
// shifter's load/shift inputs, and presents each chunk to the downstream XOR
// stage (valid/ready). The keystream bytes themselves flow straight from the
// shifter's serial output; this block only produces control and status.
//
// Optional feature macro: KSEQ_BLK_COUNT_EN
//   defined   -> blk_cnt_o is a 32-bit wrapping count of completed blocks
//   undefined -> blk_cnt_o is tied to zero and no counter flops exist
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous abort of the current block
//   blk_valid_i  core presents a block on the shifter's parallel input
//   blk_ready_o  block accepted when blk_valid_i & blk_ready_o
//   load_o       shifter load strobe
//   shift_o      shifter shift strobe
//   ks_valid_o   shifter serial output holds a valid chunk
//   ks_ready_i   consumer takes the chunk when ks_valid_o & ks_ready_i
//   ks_last_o    presented chunk is the final chunk of its block
//   chunk_idx_o  index of the presented chunk (0 = first)
//   blk_cnt_o    completed-block counter
// -----------------------------------------------------------------------------
module keystream_sequencer #(
  parameter int PARALLEL_DATA_BITS = 512,
  parameter int SHIFT_AMOUNT       = 8,
  localparam int CHUNKS            = PARALLEL_DATA_BITS / SHIFT_AMOUNT,
  localparam int IDX_W             = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  output logic             load_o,
  output logic             shift_o,
  output logic             ks_valid_o,
  input  logic             ks_ready_i,
  output logic             ks_last_o,
  output logic [IDX_W-1:0] chunk_idx_o,
  output logic [31:0]      blk_cnt_o
);

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_r;
  state_e           state_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic             load_s;
  logic             shift_s;
  logic             blk_ready_s;
  logic             ks_valid_s;
  logic             ks_last_s;
  logic             blk_done_s;

  // State and chunk-index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_EMPTY;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    blk_ready_s = 1'b0;
    ks_valid_s  = 1'b0;
    ks_last_s   = 1'b0;
    blk_done_s  = 1'b0;
    if (flush_i) begin
      // Abort: everything quiet this cycle, back to EMPTY next cycle. The
      // shifter keeps stale data, which is harmless because the next block
      // always begins with a load.
      state_s = ST_EMPTY;
      idx_s   = '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          blk_ready_s = 1'b1;
          load_s      = blk_valid_i;
          if (blk_valid_i) begin
            state_s = ST_ACTIVE;
            idx_s   = '0;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ACTIVE: begin
          ks_valid_s = 1'b1;
          ks_last_s  = (idx_r == LAST_IDX);
          if (ks_ready_i) begin
            if (idx_r != LAST_IDX) begin
              shift_s = 1'b1;
              idx_s   = idx_r + IDX_ONE;
            end else begin
              // Final chunk consumed: ready is passed straight through so a
              // waiting block loads in this same cycle with no bubble.
              blk_done_s  = 1'b1;
              blk_ready_s = 1'b1;
              idx_s       = '0;
              if (blk_valid_i) begin
                load_s  = 1'b1;
                state_s = ST_ACTIVE;
              end else begin
                state_s = ST_EMPTY;
              end
            end
          end else begin
            // Stall: no shift, so the serial chunk stays stable.
            state_s = ST_ACTIVE;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          idx_s   = '0;
        end
      endcase
    end
  end

  // Outputs are quiet while reset is held; state is already EMPTY then, and
  // this keeps blk_ready_o/load_o low until reset is released.
  assign blk_ready_o = blk_ready_s & rst_ni;
  assign load_o      = load_s & rst_ni;
  assign shift_o     = shift_s & rst_ni;
  assign ks_valid_o  = ks_valid_s & rst_ni;
  assign ks_last_o   = ks_last_s & rst_ni;
  assign chunk_idx_o = idx_r;

`ifdef KSEQ_BLK_COUNT_EN
  logic [31:0] blk_cnt_r;

  // Completed-block counter; survives flush, wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_cnt_r <= 32'd0;
    end else if (blk_done_s) begin
      blk_cnt_r <= blk_cnt_r + 32'd1;
    end else begin
      blk_cnt_r <= blk_cnt_r;
    end
  end

  assign blk_cnt_o = blk_cnt_r;
`else
  logic unused_blk_done_s;

  assign unused_blk_done_s = blk_done_s;
  assign blk_cnt_o         = 32'd0;
`endif

endmodule

// File: tb/tb_keystream_sequencer.sv
module tb_keystream_sequencer;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        blk_valid_i;
  logic        blk_ready_o;
  logic        load_o;
  logic        shift_o;
  logic        ks_valid_o;
  logic        ks_ready_i;
  logic        ks_last_o;
  logic [5:0]  chunk_idx_o;
  logic [31:0] blk_cnt_o;

`ifdef KSEQ_BLK_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  keystream_sequencer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .load_o      (load_o),
    .shift_o     (shift_o),
    .ks_valid_o  (ks_valid_o),
    .ks_ready_i  (ks_ready_i),
    .ks_last_o   (ks_last_o),
    .chunk_idx_o (chunk_idx_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct packed {
    logic [5:0] idx;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] blk_data;
  logic [511:0] sh;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc_valid = 0;
  int           cyc_shift = 0;
  int           cyc_load = 0;
  int           cyc_last = 0;
  int           ls_viol = 0;
  logic [31:0]  done_cnt = 32'd0;
  logic [31:0]  done_ref = 32'd0;
  logic [31:0]  cnt_ref = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] make_block(input int seed);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) begin
      d[8*k +: 8] = 8'(seed * 29 + k * 7 + 3);
    end
    return d;
  endfunction

  task automatic push_block(input logic [511:0] d);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.idx  = 6'(k);
      e.last = (k == 63);
      e.data = d[8*k +: 8];
      exp_q.push_back(e);
    end
  endtask

  // Reference PISO shifter: load parallel data, shift right one byte per strobe.
  always @(posedge clk_i) begin
    if (load_o) sh <= blk_data;
    else if (shift_o) sh <= sh >> 8;
  end

  // Monitor: pops the scoreboard on every accepted chunk.
  always @(negedge clk_i) begin
    exp_t e;
    logic [31:0] exp_cnt;
    if (load_o && shift_o) ls_viol++;
    if (ks_valid_o) cyc_valid++;
    if (shift_o) cyc_shift++;
    if (load_o) cyc_load++;
    if (ks_valid_o && ks_last_o) cyc_last++;
    if (ks_valid_o && ks_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_chunk: got idx %0d expected none", chunk_idx_o);
      end else begin
        e = exp_q.pop_front();
        exp_cnt = CNT_EN ? (cnt_ref + (done_cnt - done_ref)) : 32'd0;
        check("chunk_idx", 32'(chunk_idx_o), 32'(e.idx));
        check("chunk_last", 32'(ks_last_o), 32'(e.last));
        check("chunk_byte", 32'(sh[7:0]), 32'(e.data));
        check("blk_cnt_live", blk_cnt_o, exp_cnt);
        if (e.last) done_cnt = done_cnt + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic single_block(input int seed);
    logic [511:0] d;
    int bv, bs, bl, bd;
    d = make_block(seed);
    blk_data = d;
    blk_valid_i = 1'b1;
    ks_ready_i = 1'b1;
    push_block(d);
    @(negedge clk_i);
    check("sb_load", 32'(load_o), 32'd1);
    check("sb_blk_ready", 32'(blk_ready_o), 32'd1);
    check("sb_shift_at_load", 32'(shift_o), 32'd0);
    tick();
    blk_valid_i = 1'b0;
    bv = cyc_valid; bs = cyc_shift; bl = cyc_last; bd = cyc_load;
    repeat (64) tick();
    check("sb_valid_cycles", 32'(cyc_valid - bv), 32'd64);
    check("sb_shift_cycles", 32'(cyc_shift - bs), 32'd63);
    check("sb_last_cycles", 32'(cyc_last - bl), 32'd1);
    check("sb_no_extra_load", 32'(cyc_load - bd), 32'd0);
    @(negedge clk_i);
    check("sb_end_valid", 32'(ks_valid_o), 32'd0);
    check("sb_end_ready", 32'(blk_ready_o), 32'd1);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    logic [511:0] d1;
    logic [511:0] d2;
    int bv, bs, bl, bd, eidx;
    bit rdy;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    blk_valid_i = 1'b1;
    ks_ready_i = 1'b0;
    blk_data = 512'd0;
    #2;
    check("rst_blk_ready", 32'(blk_ready_o), 32'd0);
    check("rst_load", 32'(load_o), 32'd0);
    check("rst_ks_valid", 32'(ks_valid_o), 32'd0);
    check("rst_idx", 32'(chunk_idx_o), 32'd0);
    check("rst_blk_cnt", blk_cnt_o, 32'd0);
    blk_valid_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_blk_ready", 32'(blk_ready_o), 32'd1);
    check("idle_ks_valid", 32'(ks_valid_o), 32'd0);
    check("idle_shift", 32'(shift_o), 32'd0);
    check("idle_last", 32'(ks_last_o), 32'd0);
    tick();

    // Single block
    single_block(1);

    // Back-to-back blocks
    d1 = make_block(2);
    d2 = make_block(3);
    blk_data = d1;
    blk_valid_i = 1'b1;
    ks_ready_i = 1'b1;
    push_block(d1);
    push_block(d2);
    tick();
    blk_data = d2;
    bv = cyc_valid; bs = cyc_shift; bl = cyc_last; bd = cyc_load;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk_i);
      if (i == 63) begin
        check("b2b_blk_ready", 32'(blk_ready_o), 32'd1);
        check("b2b_load", 32'(load_o), 32'd1);
        check("b2b_shift", 32'(shift_o), 32'd0);
        check("b2b_last", 32'(ks_last_o), 32'd1);
      end
      tick();
      if (i == 63) blk_valid_i = 1'b0;
    end
    check("b2b_valid_cycles", 32'(cyc_valid - bv), 32'd128);
    check("b2b_load_cycles", 32'(cyc_load - bd), 32'd1);
    check("b2b_shift_cycles", 32'(cyc_shift - bs), 32'd126);
    check("b2b_last_cycles", 32'(cyc_last - bl), 32'd2);
    @(negedge clk_i);
    check("b2b_end_valid", 32'(ks_valid_o), 32'd0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Backpressure with ready pattern 1,0,0,1
    d1 = make_block(4);
    blk_data = d1;
    blk_valid_i = 1'b1;
    push_block(d1);
    tick();
    blk_valid_i = 1'b0;
    eidx = 0;
    for (int i = 0; i < 128; i++) begin
      rdy = ((i % 4) == 0) || ((i % 4) == 3);
      ks_ready_i = rdy;
      @(negedge clk_i);
      check("bp_valid", 32'(ks_valid_o), 32'd1);
      check("bp_idx", 32'(chunk_idx_o), 32'(eidx));
      check("bp_shift", 32'(shift_o), 32'(rdy && (eidx != 63)));
      check("bp_serial", 32'(sh[7:0]), 32'(d1[8*eidx +: 8]));
      if (rdy) eidx++;
      tick();
    end
    ks_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_end_valid", 32'(ks_valid_o), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Flush at idx 20
    d1 = make_block(5);
    blk_data = d1;
    blk_valid_i = 1'b1;
    push_block(d1);
    tick();
    blk_valid_i = 1'b0;
    repeat (20) tick();
    flush_i = 1'b1;
    blk_valid_i = 1'b1;
    @(negedge clk_i);
    check("fl_ks_valid", 32'(ks_valid_o), 32'd0);
    check("fl_shift", 32'(shift_o), 32'd0);
    check("fl_load", 32'(load_o), 32'd0);
    check("fl_blk_ready", 32'(blk_ready_o), 32'd0);
    check("fl_idx_before", 32'(chunk_idx_o), 32'd20);
    tick();
    flush_i = 1'b0;
    blk_valid_i = 1'b0;
    check("fl_remaining", 32'(exp_q.size()), 32'd44);
    exp_q.delete();
    @(negedge clk_i);
    check("fl_post_valid", 32'(ks_valid_o), 32'd0);
    check("fl_post_ready", 32'(blk_ready_o), 32'd1);
    check("fl_post_idx", 32'(chunk_idx_o), 32'd0);
    check("fl_blk_cnt", blk_cnt_o, CNT_EN ? (cnt_ref + (done_cnt - done_ref)) : 32'd0);
    tick();
    single_block(6);

    // Asynchronous reset at idx 40
    d1 = make_block(7);
    blk_data = d1;
    blk_valid_i = 1'b1;
    push_block(d1);
    tick();
    blk_valid_i = 1'b0;
    repeat (40) tick();
    blk_valid_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    check("ar_ks_valid", 32'(ks_valid_o), 32'd0);
    check("ar_load", 32'(load_o), 32'd0);
    check("ar_shift", 32'(shift_o), 32'd0);
    check("ar_blk_ready", 32'(blk_ready_o), 32'd0);
    check("ar_last", 32'(ks_last_o), 32'd0);
    check("ar_idx", 32'(chunk_idx_o), 32'd0);
    check("ar_blk_cnt", blk_cnt_o, 32'd0);
    blk_valid_i = 1'b0;
    exp_q.delete();
    cnt_ref = 32'd0;
    done_ref = done_cnt;
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("ar_post_ready", 32'(blk_ready_o), 32'd1);
    check("ar_post_valid", 32'(ks_valid_o), 32'd0);
    check("ar_post_cnt", blk_cnt_o, 32'd0);
    tick();

    // Block counter
    repeat (3) single_block(8);
`ifdef KSEQ_BLK_COUNT_EN
    check("cnt_three", blk_cnt_o, 32'd3);
    force dut.blk_cnt_r = 32'hFFFF_FFFF;
    tick();
    release dut.blk_cnt_r;
    cnt_ref = 32'hFFFF_FFFF;
    done_ref = done_cnt;
    check("cnt_preload", blk_cnt_o, 32'hFFFF_FFFF);
    single_block(9);
    check("cnt_wrap", blk_cnt_o, 32'd0);
`else
    check("cnt_disabled", blk_cnt_o, 32'd0);
`endif

    check("load_shift_exclusive", 32'(ls_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keystream_sequencer.md
Name: keystream_sequencer

Overview:
- Controller that sequences the ChaCha20 keystream PISO shifter, which holds 512 bits and shifts out 8-bit chunks.
- Accepts finished 512-bit blocks from the ChaCha20 core over a valid/ready handshake and issues load/shift strobes to the shifter.
- Presents each chunk to the downstream consumer over a valid/ready handshake.
- Sits between the block core and the byte-wide XOR/output stage. Keystream data itself flows directly from the shifter's serial output; this block only drives control and status.

Parameters:
- PARALLEL_DATA_BITS, 512, width of one keystream block; must be an integer multiple of SHIFT_AMOUNT.
- SHIFT_AMOUNT, 8, bits emitted per chunk; must equal the shifter's SHIFT_AMOUNT.
- Derived: CHUNKS = PARALLEL_DATA_BITS/SHIFT_AMOUNT (default 64); IDX_W = max(1, clog2(CHUNKS)) (default 6).

Ports:
- clk_i  in  1  sole clock, rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- flush_i  in  1  synchronous abort; discards the current block
- blk_valid_i  in  1  core has a block on the shifter's parallel input
- blk_ready_o  out  1  block accepted this cycle when valid&ready
- load_o  out  1  to shifter load_i
- shift_o  out  1  to shifter shift_i
- ks_valid_o  out  1  shifter serial output holds a valid chunk
- ks_ready_i  in  1  consumer takes the chunk when valid&ready
- ks_last_o  out  1  current chunk is chunk CHUNKS-1 of its block
- chunk_idx_o  out  IDX_W  index of the presented chunk (0 = first)
- blk_cnt_o  out  32  completed-block counter (see Optional Feature)

Behaviour:
- Reset (rst_ni=0, asynchronous): state=EMPTY, idx=0, blk_cnt=0. All outputs are 0, except blk_ready_o, which is 1 once out of reset in EMPTY.
- States are EMPTY and ACTIVE.
- EMPTY:
  - blk_ready_o=1, ks_valid_o=0, shift_o=0.
  - load_o = blk_valid_i & ~flush_i.
  - On load: next state ACTIVE, idx=0.
- ACTIVE:
  - ks_valid_o=1; chunk_idx_o=idx; ks_last_o=(idx==CHUNKS-1).
  - Accept condition acc = ks_valid_o & ks_ready_i & ~flush_i.
  - acc with idx<CHUNKS-1: shift_o=1, idx+1, stay ACTIVE.
  - acc with idx==CHUNKS-1:
    - blk_ready_o=1 (combinational from ks_ready_i). This is the only ready-to-ready combinational path.
    - If blk_valid_i also high: load_o=1, shift_o=0, idx=0, stay ACTIVE. This gives zero-bubble back-to-back blocks.
    - Otherwise: shift_o=0, go to EMPTY.
  - Otherwise: blk_ready_o=0, load_o=0, shift_o=0. ks_valid_o holds; chunk data is stable while stalled.
- Latency:
  - Block accept to first ks_valid_o: 1 cycle (shifter registers the load).
  - Sustained throughput: 1 chunk/cycle, including across block boundaries.
- load_o and shift_o are never asserted in the same cycle.
- flush_i (any state):
  - Same cycle: load_o=0, shift_o=0, blk_ready_o=0, ks_valid_o forced 0.
  - Next cycle: state=EMPTY, idx=0. blk_cnt is unchanged.
  - Stale shifter contents are ignored; no shifter clear is needed.
- Reset mid-block drops the block; the same rules as flush apply. The shifter has its own reset and the sequencer never reads shifter contents.
- Outputs load_o, shift_o, blk_ready_o and ks_valid_o are combinational from state and inputs.

Optional Feature:
- Macro: KSEQ_BLK_COUNT_EN.
- Defined:
  - blk_cnt_o is a 32-bit register, incremented on every acc of chunk CHUNKS-1.
  - Wraps 0xFFFFFFFF->0.
  - Reset to 0; flush does not clear it.
- Undefined: blk_cnt_o tied to 32'd0; no counter flops.

Test Plan:
- Single block: reset, blk_valid_i=1 for one cycle, ks_ready_i=1.
  - Expect load_o pulse, then ks_valid_o high for exactly 64 consecutive cycles with chunk_idx_o 0..63.
  - Expect shift_o high for 63 of them and ks_last_o only at idx 63; the shifter emits parallel_i bytes LSB first.
  - Then EMPTY with blk_ready_o=1.
- Back-to-back: blk_valid_i held high, ks_ready_i=1. At idx 63, expect blk_ready_o=1, load_o=1, shift_o=0; the next cycle shows idx 0 of block 2 with no bubble. 128 chunks in 129 cycles.
- Backpressure: ks_ready_i pattern 1,0,0,1 repeated. idx advances only on ready cycles; shift_o=0 on stall cycles; serial data is constant while stalled.
- Flush at idx 20 while ks_ready_i=1: same cycle ks_valid_o=0, shift_o=0. Next cycle EMPTY, idx=0. A new block then starts at idx 0.
- Async reset at idx 40: all outputs drop immediately, without a clock edge. After release: EMPTY, blk_ready_o=1, blk_cnt_o=0.
- KSEQ_BLK_COUNT_EN defined:
  - 3 full blocks: blk_cnt_o=3.
  - Preload counter to 0xFFFFFFFF (force), complete a block: blk_cnt_o=0.
  - Undefined: blk_cnt_o=0 throughout.
